// File: rtl/pe_col_drain.sv
// Column drain collector: captures ROWS words from the bottom PE row, narrows and buffers them for the output writer.
// Optional signed saturation on narrowing is enabled by defining PE_COL_DRAIN_SAT_EN; default build truncates.
module pe_col_drain #(
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int IN_WIDTH   = 48,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          drain_start_in,
  input  logic [IN_WIDTH-1:0]           bottom_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow_err,
  output logic                          protocol_err,
  output logic                          sat_hit
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CAPTURE = 1'b1;

  logic [0:0]           r_state;
  logic [CNT_W-1:0]     r_cap_cnt;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [OCC_W-1:0]     r_count;
  logic                 r_overflow;
  logic                 r_protocol;
  logic [OUT_WIDTH:0]   r_mem [FIFO_DEPTH];

  logic                 w_capture;
  logic                 w_cap_last;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [OUT_WIDTH-1:0] w_narrow;
  logic                 w_clamp;
  logic                 w_head_last;
  logic [OUT_WIDTH-1:0] w_head_data;

  // A capture happens on the start cycle from IDLE and on every CAPTURE cycle.
  always_comb begin
    w_capture  = 1'b0;
    w_cap_last = 1'b0;
    if (r_state == S_IDLE) begin
      w_capture  = drain_start_in;
      w_cap_last = drain_start_in && (ROWS == 1);
    end else begin
      w_capture  = 1'b1;
      w_cap_last = (r_cap_cnt == CNT_W'(ROWS - 1));
    end
  end

`ifdef PE_COL_DRAIN_SAT_EN
  logic w_hi_ones;
  logic w_hi_zeros;
  logic w_sat_pos;
  logic w_sat_neg;
  logic r_sat;

  // The value fits iff every bit from OUT_WIDTH-1 upward equals the sign bit.
  assign w_hi_ones  = &bottom_in[IN_WIDTH-1:OUT_WIDTH-1];
  assign w_hi_zeros = ~|bottom_in[IN_WIDTH-1:OUT_WIDTH-1];
  assign w_sat_pos  = !bottom_in[IN_WIDTH-1] && !w_hi_zeros;
  assign w_sat_neg  = bottom_in[IN_WIDTH-1] && !w_hi_ones;
  assign w_clamp    = w_sat_pos || w_sat_neg;

  always_comb begin
    w_narrow = bottom_in[OUT_WIDTH-1:0];
    if (w_sat_pos) begin
      w_narrow = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (w_sat_neg) begin
      w_narrow = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_capture && w_clamp) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_hit = r_sat;
`else
  logic w_unused_hi;

  assign w_narrow    = bottom_in[OUT_WIDTH-1:0];
  assign w_clamp     = 1'b0;
  assign w_unused_hi = ^{bottom_in[IN_WIDTH-1:OUT_WIDTH], w_clamp};
  assign sat_hit     = 1'b0;
`endif

  assign w_full = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_pop  = out_valid && out_ready;
  assign w_push = w_capture && (!w_full || w_pop);
  assign w_drop = w_capture && w_full && !w_pop;

  // Capture sequencing; a start pulse during CAPTURE is only flagged, never acted on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cap_cnt  <= '0;
      r_protocol <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (drain_start_in && (ROWS > 1)) begin
            r_state   <= S_CAPTURE;
            r_cap_cnt <= CNT_W'(1);
          end
        end
        default: begin
          if (drain_start_in) begin
            r_protocol <= 1'b1;
          end
          if (w_cap_last) begin
            r_state   <= S_IDLE;
            r_cap_cnt <= '0;
          end else begin
            r_cap_cnt <= r_cap_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_cap_last, w_narrow};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + OCC_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - OCC_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign {w_head_last, w_head_data} = r_mem[r_rd_ptr];

  assign out_valid    = (r_count != '0);
  assign out_data     = out_valid ? w_head_data : '0;
  assign out_last     = out_valid && w_head_last;
  assign busy         = (r_state == S_CAPTURE);
  assign fifo_count   = r_count;
  assign overflow_err = r_overflow;
  assign protocol_err = r_protocol;

endmodule

// File: tb/tb_pe_col_drain.sv
// Self-checking bench for pe_col_drain (ROWS=4, FIFO_DEPTH=8, OUT_WIDTH=32): vector table, corner sequences, random vs model.
module tb_pe_col_drain;

  localparam int ROWS       = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int IN_WIDTH   = 48;
  localparam int OUT_WIDTH  = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 drain_start_in;
  logic [IN_WIDTH-1:0]  bottom_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic [3:0]           fifo_count;
  logic                 overflow_err;
  logic                 protocol_err;
  logic                 sat_hit;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic        last;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        start;
    logic [47:0] data;
    logic        ready;
    logic        expValid;
    logic [31:0] expData;
    logic        expLast;
    logic        expBusy;
    int          expCount;
    logic        expSat;
  } vec_t;

  ent_t modelQ[$];
  int   mRemain;
  bit   mOvf;
  bit   mProto;
  bit   mSat;
  vec_t vecs[10];
  int   pops;

  pe_col_drain #(
    .ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drain_start_in(drain_start_in), .bottom_in(bottom_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .fifo_count(fifo_count), .overflow_err(overflow_err),
    .protocol_err(protocol_err), .sat_hit(sat_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isClamped(input logic [47:0] v);
`ifdef PE_COL_DRAIN_SAT_EN
    longint s;
    s = longint'($signed(v));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] narrowRef(input logic [47:0] v);
`ifdef PE_COL_DRAIN_SAT_EN
    longint s;
    s = longint'($signed(v));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a drain is ROWS consecutive captures; the buffer is a bounded queue.
  task automatic modelStep(input logic start, input logic [47:0] data, input logic ready);
    bit   cap;
    bit   lst;
    bit   pop;
    ent_t e;
    cap = 1'b0;
    lst = 1'b0;
    if (mRemain == 0) begin
      if (start) begin
        cap     = 1'b1;
        lst     = (ROWS == 1);
        mRemain = ROWS - 1;
      end
    end else begin
      cap = 1'b1;
      lst = (mRemain == 1);
      mRemain--;
      if (start) mProto = 1'b1;
    end
    pop = (modelQ.size() > 0) && ready;
    if (pop) void'(modelQ.pop_front());
    if (cap) begin
      if (isClamped(data)) mSat = 1'b1;
      if (modelQ.size() == FIFO_DEPTH) begin
        mOvf = 1'b1;
      end else begin
        e.last = lst;
        e.data = narrowRef(data);
        modelQ.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [47:0] data, input logic ready);
    drain_start_in = start;
    bottom_in      = data;
    out_ready      = ready;
    if (out_valid && ready) pops++;
    @(posedge clk);
    modelStep(start, data, ready);
    #1;
  endtask

  task automatic checkOutput();
    logic        ev;
    logic [31:0] ed;
    logic        el;
    ev = (modelQ.size() > 0);
    ed = ev ? modelQ[0].data : 32'd0;
    el = ev ? modelQ[0].last : 1'b0;
    checkVal("out_valid", 64'(out_valid), 64'(ev));
    checkVal("out_data", 64'(out_data), 64'(ed));
    checkVal("out_last", 64'(out_last), 64'(el));
    checkVal("busy", 64'(busy), 64'(mRemain > 0));
    checkVal("fifo_count", 64'(fifo_count), 64'(modelQ.size()));
    checkVal("overflow_err", 64'(overflow_err), 64'(mOvf));
    checkVal("protocol_err", 64'(protocol_err), 64'(mProto));
    checkVal("sat_hit", 64'(sat_hit), 64'(mSat));
  endtask

  task automatic applyReset(input logic start, input logic [47:0] data);
    rst_n          = 1'b0;
    drain_start_in = start;
    bottom_in      = data;
    out_ready      = 1'b1;
    @(posedge clk);
    modelQ.delete();
    mRemain = 0;
    mOvf    = 1'b0;
    mProto  = 1'b0;
    mSat    = 1'b0;
    #1;
    checkVal("reset out_valid", 64'(out_valid), 64'd0);
    checkVal("reset out_data", 64'(out_data), 64'd0);
    checkVal("reset out_last", 64'(out_last), 64'd0);
    checkVal("reset busy", 64'(busy), 64'd0);
    checkVal("reset fifo_count", 64'(fifo_count), 64'd0);
    checkVal("reset overflow_err", 64'(overflow_err), 64'd0);
    checkVal("reset protocol_err", 64'(protocol_err), 64'd0);
    checkVal("reset sat_hit", 64'(sat_hit), 64'd0);
    rst_n          = 1'b1;
    drain_start_in = 1'b0;
  endtask

  task automatic runDrain(input logic [47:0] base, input logic ready);
    for (int k = 0; k < ROWS; k++) begin
      applyStimulus(k == 0, base + 48'(k), ready);
      checkOutput();
    end
  endtask

  initial begin
    logic [47:0] rd;
    logic        rs;
    logic        rr;

    rst_n          = 1'b0;
    drain_start_in = 1'b0;
    bottom_in      = '0;
    out_ready      = 1'b0;
    pops           = 0;
    mRemain        = 0;

    vecs[0] = '{1'b1, 48'd10, 1'b1, 1'b1, 32'd10, 1'b0, 1'b1, 1, 1'b0};
    vecs[1] = '{1'b0, 48'd20, 1'b1, 1'b1, 32'd20, 1'b0, 1'b1, 1, 1'b0};
    vecs[2] = '{1'b0, 48'd30, 1'b1, 1'b1, 32'd30, 1'b0, 1'b1, 1, 1'b0};
    vecs[3] = '{1'b0, 48'd40, 1'b1, 1'b1, 32'd40, 1'b1, 1'b0, 1, 1'b0};
    vecs[4] = '{1'b0, 48'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 0, 1'b0};
`ifdef PE_COL_DRAIN_SAT_EN
    vecs[5] = '{1'b1, 48'h0001_0000_0007, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1'b1};
    vecs[6] = '{1'b0, 48'hFFFF_FFFF_FFFB, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 1, 1'b1};
    vecs[7] = '{1'b0, 48'h0000_8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1'b1};
    vecs[8] = '{1'b0, 48'h0000_0000_0005, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1, 1'b1};
    vecs[9] = '{1'b0, 48'd0,              1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b1};
`else
    vecs[5] = '{1'b1, 48'h0001_0000_0007, 1'b1, 1'b1, 32'h0000_0007, 1'b0, 1'b1, 1, 1'b0};
    vecs[6] = '{1'b0, 48'hFFFF_FFFF_FFFB, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 1, 1'b0};
    vecs[7] = '{1'b0, 48'h0000_8000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b0};
    vecs[8] = '{1'b0, 48'h0000_0000_0005, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1, 1'b0};
    vecs[9] = '{1'b0, 48'd0,              1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0};
`endif

    @(negedge clk);
    applyReset(1'b1, 48'd99);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].start, vecs[i].data, vecs[i].ready);
      checkVal($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].expValid));
      checkVal($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].expData));
      checkVal($sformatf("vec%0d out_last", i), 64'(out_last), 64'(vecs[i].expLast));
      checkVal($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].expBusy));
      checkVal($sformatf("vec%0d fifo_count", i), 64'(fifo_count), 64'(vecs[i].expCount));
      checkVal($sformatf("vec%0d sat_hit", i), 64'(sat_hit), 64'(vecs[i].expSat));
    end

    // Back-pressure: two drains fill the buffer, a third is dropped entirely.
    applyReset(1'b0, 48'd0);
    runDrain(48'h100, 1'b0);
    runDrain(48'h200, 1'b0);
    checkVal("bp fifo_count full", 64'(fifo_count), 64'd8);
    checkVal("bp overflow clear", 64'(overflow_err), 64'd0);
    runDrain(48'h300, 1'b0);
    checkVal("bp fifo_count after drop", 64'(fifo_count), 64'd8);
    checkVal("bp overflow set", 64'(overflow_err), 64'd1);
    checkVal("bp head kept", 64'(out_data), 64'h100);

    // Full buffer with simultaneous push and pop keeps occupancy at eight.
    for (int k = 0; k < ROWS; k++) begin
      applyStimulus(k == 0, 48'h400 + 48'(k), 1'b1);
      checkOutput();
      checkVal($sformatf("full pushpop count%0d", k), 64'(fifo_count), 64'd8);
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 48'd0, 1'b1);
      checkOutput();
    end
    checkVal("full drained", 64'(fifo_count), 64'd0);

    // Protocol error: start pulse on capture index 2 is ignored.
    applyReset(1'b0, 48'd0);
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k == 0 || k == 2, 48'h500 + 48'(k), 1'b1);
      checkOutput();
    end
    checkVal("proto err set", 64'(protocol_err), 64'd1);
    checkVal("proto words out", 64'(pops), 64'd4);

    // Mid-drain reset discards everything; a fresh drain then works.
    applyReset(1'b0, 48'd0);
    applyStimulus(1'b1, 48'd100, 1'b0);
    checkOutput();
    applyReset(1'b0, 48'd200);
    pops = 0;
    runDrain(48'h600, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 48'd0, 1'b1);
      checkOutput();
    end
    checkVal("post reset words out", 64'(pops), 64'd4);

    // Randomized traffic against the model.
    applyReset(1'b0, 48'd0);
    for (int c = 0; c < 600; c++) begin
      rs = ($urandom_range(0, 4) == 0);
      rr = (c % 150 < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: rd = 48'($urandom_range(0, 1000));
        1: rd = -48'($urandom_range(1, 1000));
        default: rd = {16'($urandom), 32'($urandom)};
      endcase
      if (c == 300) begin
        applyReset(rs, rd);
      end else begin
        applyStimulus(rs, rd, rr);
        checkOutput();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
